// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the serial shift-chain sequencer.
package shift_seq_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_seq_bitcnt.sv
// Shift-cycle counter with a registered "final shift in progress" flag.
module shift_seq_bitcnt
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // The flag is precomputed from the next count so the FSM sees it
  // straight from a flop during the cycle where cnt == WIDTH-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      last <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      last <= (cnt_nxt == LAST_CNT);
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial / serial-to-parallel sequencer for a WIDTH-stage shift chain.
// Define SHIFT_SEQ_MSB_FIRST_EN to stream MSB first; default build is LSB first.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             shift_en,
  output logic             sout,
  input  logic             sin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 64) begin : g_width_chk
    $error("shift_seq_ctrl: WIDTH must be in 2..64");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic             head_bit;
  logic             accept;
  logic             shifting;
  logic             last;

  assign accept   = (state == IDLE) && in_valid;
  assign shifting = (state == SHIFT);

`ifdef SHIFT_SEQ_MSB_FIRST_EN
  assign head_bit      = shreg[WIDTH-1];
  assign shreg_shifted = {shreg[WIDTH-2:0], sin};
`else
  assign head_bit      = shreg[0];
  assign shreg_shifted = {sin, shreg[WIDTH-1:1]};
`endif

  shift_seq_bitcnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bitcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .inc   (shifting),
    .last  (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs depend only on state and shreg, never directly on inputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    shift_en  = 1'b0;
    sout      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        sout     = head_bit;
        busy     = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = shreg;
        busy      = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // shreg holds the outgoing word and fills with returning bits as it drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= in_data;
    end else if (shifting) begin
      shreg <= shreg_shifted;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (WIDTH=8); honours SHIFT_SEQ_MSB_FIRST_EN.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       shift_en;
  logic       sout;
  logic       sin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  logic       sin_drv   = 1'b0;
  logic       use_chain = 1'b0;
  logic [7:0] chain     = 8'h00;

  int checks = 0;
  int errors = 0;

`ifdef SHIFT_SEQ_MSB_FIRST_EN
  localparam logic [7:0] PAT_B2B_0  = 8'h80;
  localparam logic [7:0] PAT_B2B_1  = 8'h01;
  localparam logic [7:0] EXP_PAT    = 8'h80;
  localparam logic [7:0] EXP_SEQ_0F = 8'hF0;
`else
  localparam logic [7:0] PAT_B2B_0  = 8'h01;
  localparam logic [7:0] PAT_B2B_1  = 8'h80;
  localparam logic [7:0] EXP_PAT    = 8'h01;
  localparam logic [7:0] EXP_SEQ_0F = 8'h0F;
`endif

  shift_seq_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .shift_en  (shift_en),
    .sout      (sout),
    .sin       (sin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // 8-flop model of the external chain, advancing only on shift_en
  always @(posedge clk) begin
    if (shift_en) chain <= {sout, chain[7:1]};
  end

  assign sin = use_chain ? chain[0] : sin_drv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives sin from pat (bit n in shift cycle n) and records sout per shift cycle.
  task automatic shift_phase(input logic [7:0] pat, output int n, output logic [7:0] sseq);
    n = 0;
    sseq = 8'h00;
    while (shift_en && n < 20) begin
      if (n < 8) begin
        sseq[n] = sout;
        sin_drv = pat[n];
      end
      n++;
      tick();
    end
    sin_drv = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    checks++;
    if ({in_ready, shift_en, sout, out_valid, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 10000", {in_ready, shift_en, sout, out_valid, busy});
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h expected 00", out_data);
    end
    @(negedge clk) reset = 1'b0;
    tick();
    checks++;
    if ({in_ready, shift_en, out_valid, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 1000", {in_ready, shift_en, out_valid, busy});
    end
  endtask

  task automatic test_loopback();
    int n;
    logic [7:0] sseq;
    logic [7:0] exp;
    use_chain = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      exp = (pass == 0) ? 8'h00 : 8'hA5;
      in_data = 8'hA5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      shift_phase(8'h00, n, sseq);
      checks++;
      if (n !== 8) begin errors++; $display("FAIL loop_shift_cycles: got %0d expected 8", n); end
      checks++;
      if (sseq !== 8'hA5) begin errors++; $display("FAIL loop_sout_seq: got %h expected a5", sseq); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++;
        $display("FAIL loop_result: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, exp);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL loop_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
      end
    end
    use_chain = 1'b0;
  endtask

  task automatic test_tied();
    logic [7:0] din [2];
    logic [7:0] pat [2];
    logic [7:0] exp [2];
    int n;
    logic [7:0] sseq;
    din = '{8'h00, 8'hFF};
    pat = '{8'hFF, 8'h00};
    exp = '{8'hFF, 8'h00};
    for (int i = 0; i < 2; i++) begin
      in_data = din[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      shift_phase(pat[i], n, sseq);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        errors++;
        $display("FAIL tied_%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, exp[i]);
      end
      checks++;
      if (sseq !== din[i]) begin errors++; $display("FAIL tied_sout_%0d: got %h expected %h", i, sseq, din[i]); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_stall();
    int n;
    logic [7:0] sseq;
    in_data = 8'h96; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    shift_phase(8'hFF, n, sseq);
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hFF || in_ready !== 1'b0 || shift_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: got valid=%b data=%h in_ready=%b shift_en=%b expected 1 ff 0 0",
                 c, out_valid, out_data, in_ready, shift_en);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || shift_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got in_ready=%b out_valid=%b shift_en=%b expected 1 0 0", in_ready, out_valid, shift_en);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (shift_en !== 1'b1) begin errors++; $display("FAIL stall_accept: got shift_en=%b expected 1", shift_en); end
    shift_phase(8'h00, n, sseq);
    checks++;
    if (n !== 8 || sseq !== 8'h3C || out_data !== 8'h00) begin
      errors++;
      $display("FAIL stall_second: got n=%0d sout=%h data=%h expected 8 3c 00", n, sseq, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int n;
    logic [7:0] sseq;
    bit seen_valid;
    in_data = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (shift_en !== 1'b1) begin errors++; $display("FAIL abort_mid_shift: got shift_en=%b expected 1", shift_en); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, shift_en, sout, out_valid, busy} !== 5'b10000 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL abort_outputs: got %b data=%h expected 10000 data=00",
               {in_ready, shift_en, sout, out_valid, busy}, out_data);
    end
    @(negedge clk) reset = 1'b0;
    tick();
    seen_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid !== 1'b0 || shift_en !== 1'b0) seen_valid = 1'b1;
      tick();
    end
    checks++;
    if (seen_valid) begin errors++; $display("FAIL abort_no_resume: got activity=1 expected 0"); end
    in_data = 8'h81; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    shift_phase(8'h81, n, sseq);
    checks++;
    if (n !== 8 || out_valid !== 1'b1 || out_data !== 8'h81) begin
      errors++;
      $display("FAIL abort_next_word: got n=%0d valid=%b data=%h expected 8 1 81", n, out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int at [2];
    int rt [2];
    logic [7:0] res [2];
    logic [7:0] pat [2];
    int k = 0;
    int got = 0;
    int sidx = 0;
    pat = '{PAT_B2B_0, PAT_B2B_1};
    at = '{-1, -1}; rt = '{-1, -1}; res = '{8'hxx, 8'hxx};
    in_data = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (out_valid && got < 2) begin res[got] = out_data; rt[got] = c; got++; end
      if (in_valid && in_ready && k < 2) begin at[k] = c; k++; sidx = 0; end
      if (shift_en && k > 0 && sidx < 8) begin sin_drv = pat[k-1][sidx]; sidx++; end
      if (k == 1 && shift_en) in_data = 8'h80;
      if (k == 2 && shift_en) in_valid = 1'b0;
      tick();
    end
    sin_drv = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (at[1] - at[0] !== 10) begin errors++; $display("FAIL b2b_spacing: got %0d expected 10", at[1] - at[0]); end
    checks++;
    if (rt[0] - at[0] !== 9) begin errors++; $display("FAIL b2b_latency: got %0d expected 9", rt[0] - at[0]); end
    checks++;
    if (res[0] !== 8'h01) begin errors++; $display("FAIL b2b_word0: got %h expected 01", res[0]); end
    checks++;
    if (res[1] !== 8'h80) begin errors++; $display("FAIL b2b_word1: got %h expected 80", res[1]); end
  endtask

  task automatic test_pattern();
    int n;
    logic [7:0] sseq;
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    shift_phase(8'h01, n, sseq);
    checks++;
    if (sseq !== 8'hA5 || out_data !== EXP_PAT) begin
      errors++;
      $display("FAIL pattern_a5: got sout=%h data=%h expected a5 %h", sseq, out_data, EXP_PAT);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_data = 8'h0F; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    shift_phase(8'h00, n, sseq);
    checks++;
    if (sseq !== EXP_SEQ_0F) begin errors++; $display("FAIL pattern_order: got sout=%h expected %h", sseq, EXP_SEQ_0F); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback();
    test_tied();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    test_pattern();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
